keypad_scanner: RTL and testbench

- Scans a 4x4 matrix keypad, one per player, and debounces the result.
- Produces the 4-bit key code and key-pressed level that feed the vga top's keys_1/key_pressed_1 and keys_2/key_pressed_2 inputs. Two instances are used.
- Runs in the CLOCK_50 domain, upstream of the game/image logic.
- Rows are driven active-low one at a time; columns are read active-low through external pull-ups.

---
 rtl/keypad_scanner.sv | 216 +++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low matrix scanner with frame-based debounce, one accepted key at a time.
// Define KEYPAD_REPEAT_EN for auto-repeat strobes; i_rst_n is expected to be released synchronously to i_clk.
module keypad_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_RATE    = 100
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_col,
    output logic [3:0] o_row,
    output logic [3:0] o_key,
    output logic       o_key_pressed,
    output logic       o_key_strobe
);
    localparam int               DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]       DEB_N    = 4'(DEBOUNCE_SCANS);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAND    = 2'd1;
    localparam logic [1:0] ST_PRESSED = 2'd2;
    localparam logic [1:0] ST_REL     = 2'd3;

    logic [3:0]       col_meta_q, col_sync_q;
    logic [DIV_W-1:0] div_q;
    logic [1:0]       row_q;
    logic [3:0]       row_oh_q;
    logic [11:0]      lat_q;
    logic [1:0]       state_q, state_d;
    logic [3:0]       cand_q, cand_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       key_q;
    logic             pressed_q, strobe_q;

    logic        sample, frame_end, found, is_cand, accept, drop, rep_fire;
    logic [3:0]  code;
    logic [15:0] frame_cols;

    assign sample    = (div_q == DIV_LAST);
    assign frame_end = sample && (row_q == 2'd3);
    // Row 3 is consumed straight from the synchronizer on the same edge it would be latched.
    assign frame_cols = {col_sync_q, lat_q};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col_meta_q <= 4'hF;
            col_sync_q <= 4'hF;
            div_q      <= '0;
            row_q      <= 2'd0;
            row_oh_q   <= 4'b1110;
            lat_q      <= 12'hFFF;
        end else begin
            col_meta_q <= i_col;
            col_sync_q <= col_meta_q;
            if (sample) begin
                div_q    <= '0;
                row_q    <= row_q + 2'd1;
                row_oh_q <= {row_oh_q[2:0], row_oh_q[3]};
                case (row_q)
                    2'd0:    lat_q[3:0]  <= col_sync_q;
                    2'd1:    lat_q[7:4]  <= col_sync_q;
                    2'd2:    lat_q[11:8] <= col_sync_q;
                    default: lat_q       <= lat_q;
                endcase
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        found = 1'b0;
        code  = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (!frame_cols[i]) begin
                found = 1'b1;
                code  = 4'(i);
            end
        end
    end

    assign is_cand = found && (code == cand_q);

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        drop    = 1'b0;
        if (frame_end) begin
            case (state_q)
                ST_IDLE: begin
                    if (found) begin
                        cand_d = code;
                        cnt_d  = 4'd1;
                        if (DEB_N == 4'd1) begin
                            state_d = ST_PRESSED;
                            accept  = 1'b1;
                        end else begin
                            state_d = ST_CAND;
                        end
                    end
                end
                ST_CAND: begin
                    if (is_cand) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q + 4'd1 == DEB_N) begin
                            state_d = ST_PRESSED;
                            accept  = 1'b1;
                        end
                    end else if (found) begin
                        cand_d = code;
                        cnt_d  = 4'd1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PRESSED: begin
                    if (!is_cand) begin
                        if (DEB_N == 4'd1) begin
                            state_d = ST_IDLE;
                            drop    = 1'b1;
                        end else begin
                            state_d = ST_REL;
                            cnt_d   = 4'd1;
                        end
                    end
                end
                default: begin
                    if (is_cand) begin
                        state_d = ST_PRESSED;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q + 4'd1 == DEB_N) begin
                            state_d = ST_IDLE;
                            drop    = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_DELAY_N = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_RATE_N  = REP_W'(REPEAT_RATE);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_first_q, rep_first_d;

    // Counts only frames that begin and end in PRESSED, so it freezes across a REL bounce.
    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
        rep_fire    = 1'b0;
        if (accept || state_d == ST_IDLE) begin
            rep_cnt_d   = '0;
            rep_first_d = 1'b0;
        end else if (frame_end && state_q == ST_PRESSED && state_d == ST_PRESSED) begin
            if (rep_cnt_q + REP_W'(1) == (rep_first_q ? REP_RATE_N : REP_DELAY_N)) begin
                rep_fire    = 1'b1;
                rep_cnt_d   = '0;
                rep_first_d = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + REP_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            cand_q    <= 4'd0;
            cnt_q     <= 4'd0;
            key_q     <= 4'd0;
            pressed_q <= 1'b0;
            strobe_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            strobe_q <= accept | rep_fire;
            if (accept) begin
                key_q     <= cand_d;
                pressed_q <= 1'b1;
            end else if (drop) begin
                pressed_q <= 1'b0;
            end
        end
    end

    assign o_row         = row_oh_q;
    assign o_key         = key_q;
    assign o_key_pressed = pressed_q;
    assign o_key_strobe  = strobe_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: models the key matrix, drives whole frames and scoreboards every strobe.
// Frame tables cover debounce/release cases; reset and auto-repeat run as hand-written sequences.
module tb_keypad_scanner;
    localparam int FRAME = 16;

    typedef struct {
        logic [15:0] keys;
        int          reps;
        bit          strobe;
        bit          pressed;
        logic [3:0]  key;
    } vec_t;

    typedef struct {
        int         cyc;
        logic [3:0] key;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] keys = 16'h0000;
    logic [3:0]  col;
    logic [3:0]  o_row, o_key;
    logic        o_key_pressed, o_key_strobe;

    int   cyc;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    vec_t tbl[$];

    keypad_scanner #(
        .SCAN_DIV(4),
        .DEBOUNCE_SCANS(3),
        .REPEAT_DELAY(5),
        .REPEAT_RATE(2)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_col(col),
        .o_row(o_row),
        .o_key(o_key),
        .o_key_pressed(o_key_pressed),
        .o_key_strobe(o_key_strobe)
    );

    always #5 clk = ~clk;

    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!o_row[r] && keys[r*4+c]) col[c] = 1'b0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Strobe scoreboard: any strobe, or any expected strobe cycle, is compared.
    always @(negedge clk) begin
        if (rst_n && (o_key_strobe || (sb.size() > 0 && sb[0].cyc == cyc))) begin
            check("strobe_at_cycle", o_key_strobe, (sb.size() > 0 && sb[0].cyc == cyc));
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                check("strobe_key", o_key, sb[0].key);
                sb.delete(0);
            end
        end
    end

    // Called at a frame boundary (negedge, cyc multiple of FRAME); returns at the next one.
    task automatic apply_frame(input logic [15:0] k, input bit stb, input bit exp_p,
                               input logic [3:0] exp_k, input string tag);
        exp_t e;
        keys = k;
        if (stb) begin
            e.cyc = cyc + FRAME;
            e.key = exp_k;
            sb.push_back(e);
        end
        repeat (FRAME) @(negedge clk);
        check({tag, "_pressed"}, o_key_pressed, exp_p);
        check({tag, "_key"}, o_key, exp_k);
    endtask

    task automatic add(input logic [15:0] k, input int n, input bit s, input bit p, input logic [3:0] key);
        vec_t v;
        v.keys = k; v.reps = n; v.strobe = s; v.pressed = p; v.key = key;
        tbl.push_back(v);
    endtask

    initial begin
        exp_t e;
        bit   rep_on;
        bit   stb;
`ifdef KEYPAD_REPEAT_EN
        rep_on = 1'b1;
`else
        rep_on = 1'b0;
`endif
        // single key 9 held, then released
        add(16'h0200, 2,  0, 0, 4'd0);
        add(16'h0200, 1,  1, 1, 4'd9);
        add(16'h0200, 20, 0, 1, 4'd9);
        add(16'h0000, 2,  0, 1, 4'd9);
        add(16'h0000, 1,  0, 0, 4'd9);
        // keys 10+5 resolve to 5; then 10 alone is accepted after release debounce
        add(16'h0420, 2,  0, 0, 4'd9);
        add(16'h0420, 1,  1, 1, 4'd5);
        add(16'h0420, 1,  0, 1, 4'd5);
        add(16'h0400, 2,  0, 1, 4'd5);
        add(16'h0400, 1,  0, 0, 4'd5);
        add(16'h0400, 2,  0, 0, 4'd5);
        add(16'h0400, 1,  1, 1, 4'd10);
        add(16'h0000, 2,  0, 1, 4'd10);
        add(16'h0000, 1,  0, 0, 4'd10);
        // key 3 with a short release bounce, then a clean release
        add(16'h0008, 2,  0, 0, 4'd10);
        add(16'h0008, 1,  1, 1, 4'd3);
        add(16'h0000, 2,  0, 1, 4'd3);
        add(16'h0008, 2,  0, 1, 4'd3);
        add(16'h0000, 2,  0, 1, 4'd3);
        add(16'h0000, 2,  0, 0, 4'd3);

        repeat (3) @(negedge clk);
        check("rst_row", o_row, 4'b1110);
        check("rst_key", o_key, 4'd0);
        check("rst_pressed", o_key_pressed, 1'b0);
        check("rst_strobe", o_key_strobe, 1'b0);
        rst_n = 1'b1;

        foreach (tbl[i])
            for (int n = 0; n < tbl[i].reps; n++)
                apply_frame(tbl[i].keys, tbl[i].strobe && (n == 0), tbl[i].pressed, tbl[i].key,
                            $sformatf("vec%0d", i));

        // key 6 bouncing: 2 frames down / 1 up never completes a debounce
        for (int n = 0; n < 10; n++) begin
            apply_frame(16'h0040, 0, 0, 4'd3, "bounce");
            apply_frame(16'h0040, 0, 0, 4'd3, "bounce");
            apply_frame(16'h0000, 0, 0, 4'd3, "bounce");
        end

        // reset mid-row-2 of the frame that would otherwise accept key 9
        apply_frame(16'h0200, 0, 0, 4'd3, "prerst");
        apply_frame(16'h0200, 0, 0, 4'd3, "prerst");
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_row", o_row, 4'b1110);
        check("midrst_key", o_key, 4'd0);
        check("midrst_pressed", o_key_pressed, 1'b0);
        check("midrst_strobe", o_key_strobe, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        e.cyc = 3 * FRAME;
        e.key = 4'd9;
        sb.push_back(e);
        for (int k = 0; k < 4; k++) begin
            #1;
            check("dwell_row0", o_row, 4'b1110);
            @(negedge clk);
        end
        #1;
        check("dwell_row1", o_row, 4'b1101);
        repeat (3 * FRAME - 4) @(negedge clk);
        check("postrst_pressed", o_key_pressed, 1'b1);
        check("postrst_key", o_key, 4'd9);
        apply_frame(16'h0000, 0, 1, 4'd9, "postrst_rel");
        apply_frame(16'h0000, 0, 1, 4'd9, "postrst_rel");
        apply_frame(16'h0000, 0, 0, 4'd9, "postrst_rel");

        // key 0 held 14 frames: accept at frame 2, repeats 5/7/9/11 frames after accept
        for (int i = 0; i < 14; i++) begin
            stb = (i == 2) || (rep_on && i - 2 >= 5 && ((i - 2 - 5) % 2 == 0));
            apply_frame(16'h0001, stb, i >= 2, (i >= 2) ? 4'd0 : 4'd9, "repeat");
        end
        apply_frame(16'h0000, 0, 1, 4'd0, "rep_rel");
        apply_frame(16'h0000, 0, 1, 4'd0, "rep_rel");
        apply_frame(16'h0000, 0, 0, 4'd0, "rep_rel");

        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
